// File: rtl/dmem_arbiter.sv
// Two-requester (cpu/host) arbiter in front of a synchronous single-port data memory.
// The cpu has priority, and a saturating wait counter keeps the host from being starved.
module dmem_arbiter #(
  parameter int AWIDTH       = 16,
  parameter int DWIDTH       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [AWIDTH-1:0] c_addr,
  input  logic [DWIDTH-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [AWIDTH-1:0] h_addr,
  input  logic [DWIDTH-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DWIDTH-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata
);

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] r_wait_cnt;
  logic       r_rd_c;
  logic       r_rd_h;
  logic       w_host_win;
  logic       w_cpu_win;

  // Reset gates the grants so nothing reaches the memory while rst is low.
  assign w_host_win = rst & h_req & (~c_req | (r_wait_cnt == LP_LIMIT));
  assign w_cpu_win  = rst & c_req & ~w_host_win;

  assign c_gnt  = w_cpu_win;
  assign h_gnt  = w_host_win;
  assign mem_en = w_cpu_win | w_host_win;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_cpu_win) begin
      mem_we    = c_we;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
    end else if (w_host_win) begin
      mem_we    = h_we;
      mem_addr  = h_addr;
      mem_wdata = h_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait_cnt <= 4'd0;
      r_rd_c     <= 1'b0;
      r_rd_h     <= 1'b0;
    end else begin
      // A withdrawn or granted host request restarts the starvation count.
      if (h_req && !w_host_win) begin
        if (r_wait_cnt != LP_LIMIT) begin
          r_wait_cnt <= r_wait_cnt + 4'd1;
        end
      end else begin
        r_wait_cnt <= 4'd0;
      end
      r_rd_c <= w_cpu_win & ~c_we;
      r_rd_h <= w_host_win & ~h_we;
    end
  end

  assign c_rvalid = r_rd_c;
  assign h_rvalid = r_rd_h;
  assign rdata    = (r_rd_c | r_rd_h) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random two-requester traffic,
// checked against a priority/starvation model and a shadow memory.
module tb_dmem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        c_req = 1'b0, c_we = 1'b0;
  logic [15:0] c_addr = '0, c_wdata = '0;
  logic        h_req = 1'b0, h_we = 1'b0;
  logic [15:0] h_addr = '0, h_wdata = '0;
  logic        c_gnt, c_rvalid, h_gnt, h_rvalid;
  logic [15:0] rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter #(.AWIDTH(16), .DWIDTH(16), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid),
    .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory seen by the arbiter.
  logic [15:0] mem [0:65535];
  logic [15:0] mem_q = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_q <= mem[mem_addr];
    end
  end
  assign mem_rdata = mem_q;

  // Reference model state.
  logic [15:0] ref_mem [0:65535];
  int          host_denied = 0;
  logic        exp_rdc = 1'b0, exp_rdh = 1'b0;
  logic [15:0] exp_rdata = '0;
  logic        last_c = 1'b0, last_h = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One arbitration cycle: inputs are already driven; check, update model, advance.
  task automatic step();
    logic        xc, xh;
    logic [63:0] xmem;
    xh = h_req && (!c_req || host_denied >= LIMIT);
    xc = c_req && !xh;
    @(negedge clk);
    chk("rvalid_rdata", {46'd0, c_rvalid, h_rvalid, rdata}, {46'd0, exp_rdc, exp_rdh, exp_rdata});
    chk("grant", {62'd0, c_gnt, h_gnt}, {62'd0, xc, xh});
    if (xc)      xmem = {30'd0, 1'b1, c_we, c_addr, c_wdata};
    else if (xh) xmem = {30'd0, 1'b1, h_we, h_addr, h_wdata};
    else         xmem = '0;
    chk("mem_bus", {30'd0, mem_en, mem_we, mem_addr, mem_wdata}, xmem);
    exp_rdc   = xc && !c_we;
    exp_rdh   = xh && !h_we;
    exp_rdata = exp_rdc ? ref_mem[c_addr] : (exp_rdh ? ref_mem[h_addr] : 16'h0);
    if (xc && c_we) ref_mem[c_addr] = c_wdata;
    if (xh && h_we) ref_mem[h_addr] = h_wdata;
    if (h_req && !xh) host_denied++;
    else              host_denied = 0;
    last_c = c_gnt;
    last_h = h_gnt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    c_req = 1'b0;
    h_req = 1'b0;
    step();
  endtask

  initial begin
    logic [9:0]  hpat;
    logic        c_pend, h_pend;
    int          h_wait;

    // Reset held with both requesters active: everything must stay quiet.
    c_req = 1'b1; h_req = 1'b1; c_we = 1'b0; h_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gnt", {62'd0, c_gnt, h_gnt}, 64'd0);
    chk("reset_mem", {30'd0, mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);
    chk("reset_rv", {46'd0, c_rvalid, h_rvalid, rdata}, 64'd0);
    c_req = 1'b0; h_req = 1'b0;
    rst = 1'b1;

    // Preload addresses 0..15 with cpu writes.
    for (int a = 0; a < 16; a++) begin
      c_req = 1'b1; c_we = 1'b1; c_addr = 16'(a); c_wdata = 16'($urandom);
      step();
    end
    c_req = 1'b0;

    // Host write 0x0042 <= 0x1234, then 0x0010 <= 0xBEEF.
    h_req = 1'b1; h_we = 1'b1; h_addr = 16'h0042; h_wdata = 16'h1234;
    step();
    h_addr = 16'h0010; h_wdata = 16'hBEEF;
    step();
    idle();

    // Single cpu read of 0x0010.
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0010;
    step();
    idle();
    chk("beef_seen", {48'd0, 16'(ref_mem[16'h0010])}, 64'hBEEF);

    // Back-to-back cpu reads.
    for (int a = 1; a <= 3; a++) begin
      c_req = 1'b1; c_we = 1'b0; c_addr = 16'(a);
      step();
    end
    idle();

    // Continuous contention: host wins every fifth cycle.
    hpat = '0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0001;
    h_req = 1'b1; h_we = 1'b0; h_addr = 16'h0002;
    for (int i = 0; i < 10; i++) begin
      step();
      hpat = {hpat[8:0], last_h};
    end
    chk("starve_pattern", {54'd0, hpat}, {54'd0, 10'b0000100001});
    idle();

    // Host withdrawal clears the wait count.
    c_req = 1'b1; h_req = 1'b1;
    step(); step(); step();
    h_req = 1'b0;
    step();
    h_req = 1'b1;
    for (int i = 0; i < 6; i++) step();
    idle();

    // Reset asserted during a granted cpu read, with the host already waiting.
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0003; h_req = 1'b1; h_we = 1'b0;
    step(); step(); step();
    @(negedge clk);
    chk("midrd_gnt", {63'd0, c_gnt}, 64'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("midrd_forced", {30'd0, c_gnt, h_gnt, mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);
    @(posedge clk);
    #1;
    chk("midrd_rv", {46'd0, c_rvalid, h_rvalid, rdata}, 64'd0);
    c_req = 1'b0; h_req = 1'b0;
    #2;
    rst = 1'b1;
    exp_rdc = 1'b0; exp_rdh = 1'b0; exp_rdata = '0; host_denied = 0;
    step();
    c_req = 1'b1; h_req = 1'b1;
    for (int i = 0; i < 5; i++) step();
    idle();

    // Random traffic with requesters holding until granted.
    c_pend = 1'b0; h_pend = 1'b0; h_wait = 0;
    for (int i = 0; i < 400; i++) begin
      if (!c_pend && $urandom_range(0, 2) != 0) begin
        c_pend = 1'b1; c_we = 1'($urandom); c_addr = 16'($urandom_range(0, 15));
        c_wdata = 16'($urandom);
      end
      if (!h_pend && $urandom_range(0, 2) != 0) begin
        h_pend = 1'b1; h_we = 1'($urandom); h_addr = 16'($urandom_range(0, 15));
        h_wdata = 16'($urandom);
      end else if (h_pend && $urandom_range(0, 15) == 0) begin
        h_pend = 1'b0;
        h_wait = 0;
      end
      c_req = c_pend; h_req = h_pend;
      step();
      if (last_c) c_pend = 1'b0;
      if (h_req) begin
        h_wait++;
        if (last_h) begin
          chk("host_wait", {63'd0, 1'(h_wait <= LIMIT + 1)}, 64'd1);
          h_pend = 1'b0;
          h_wait = 0;
        end
      end
    end
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter AWIDTH, default 16, meaning the address width.
REQ-002 The block SHALL have parameter DWIDTH, default 16, meaning the data width.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 4, legal range 1..15, meaning the maximum number of consecutive cycles host may be denied.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 The block SHALL have port c_req, input, 1 bit: the cpu request.
REQ-007 The block SHALL have port c_we, input, 1 bit: 1 for a cpu write, 0 for a cpu read.
REQ-008 The block SHALL have port c_addr, input, AWIDTH bits: the cpu address.
REQ-009 The block SHALL have port c_wdata, input, DWIDTH bits: the cpu write data.
REQ-010 The block SHALL have port c_gnt, output, 1 bit: the cpu request is accepted this cycle.
REQ-011 The block SHALL have port c_rvalid, output, 1 bit: rdata holds the cpu read result.
REQ-012 The block SHALL have port h_req, input, 1 bit: the host (loader/debug) request.
REQ-013 The block SHALL have port h_we, input, 1 bit: 1 for a host write, 0 for a host read.
REQ-014 The block SHALL have port h_addr, input, AWIDTH bits: the host address.
REQ-015 The block SHALL have port h_wdata, input, DWIDTH bits: the host write data.
REQ-016 The block SHALL have port h_gnt, output, 1 bit: the host request is accepted this cycle.
REQ-017 The block SHALL have port h_rvalid, output, 1 bit: rdata holds the host read result.
REQ-018 The block SHALL have port rdata, output, DWIDTH bits: the shared read-return data.
REQ-019 The block SHALL have port mem_en, output, 1 bit: the memory access strobe.
REQ-020 The block SHALL have port mem_we, output, 1 bit: the memory write enable.
REQ-021 The block SHALL have port mem_addr, output, AWIDTH bits: the memory address.
REQ-022 The block SHALL have port mem_wdata, output, DWIDTH bits: the memory write data.
REQ-023 The block SHALL have port mem_rdata, input, DWIDTH bits: the synchronous single-port memory read data, valid one cycle after the read strobe.

Function
REQ-024 Grant decision SHALL be combinational in the request cycle:
- If only one requester asserts req, that requester SHALL get gnt=1.
- If both assert req, cpu SHALL win unless wait_cnt == STARVE_LIMIT, in which case host SHALL win.
REQ-025 At most one of c_gnt and h_gnt SHALL be 1 in any cycle; gnt SHALL never assert without the matching req.
REQ-026 In a grant cycle, mem_en SHALL be 1, and mem_we/mem_addr/mem_wdata SHALL equal the winner's we/addr/wdata.
REQ-027 With no grant, mem_en, mem_we, mem_addr and mem_wdata SHALL all be 0.
REQ-028 wait_cnt (4-bit register) SHALL behave as follows:
- +1 on each cycle with h_req=1 and h_gnt=0, saturating at STARVE_LIMIT.
- Clear to 0 on a cycle with h_gnt=1 or h_req=0.
REQ-029 A requester SHALL hold req/we/addr/wdata stable until it sees gnt; the block SHALL accept a new request from the same requester in the cycle immediately after a grant (back-to-back, no bubble).
REQ-030 Read grant in cycle N SHALL produce x_rvalid=1 for the same requester in cycle N+1 only, with rdata = mem_rdata in that cycle.
REQ-031 The read owner SHALL be tracked by registered flags rd_c and rd_h, at most one set at a time.
REQ-032 When rd_c and rd_h are both 0, rdata SHALL be 0.
REQ-033 Write grants SHALL produce no rvalid; a write and the preceding read's rvalid MAY coincide in the same cycle.
REQ-034 A requester dropping req before gnt SHALL be treated as a withdrawn request with no side effects, and SHALL clear wait_cnt if that requester is host.

Reset
REQ-035 While rst=0, all of the following SHALL be 0 immediately (asynchronously): wait_cnt, rd_c, rd_h, c_rvalid, h_rvalid, rdata.
REQ-036 While rst=0, gnt and mem_* outputs SHALL be forced to 0 regardless of req inputs.
REQ-037 A read granted in the cycle reset asserts SHALL produce no rvalid after reset release.
REQ-038 The first cycle after rst returns to 1 SHALL arbitrate normally, with wait_cnt=0.

Verification
REQ-039 Single cpu read: c_req=1, c_we=0, c_addr=0x0010, memory[0x0010]=0xBEEF -> c_gnt=1 and mem_en=1, mem_addr=0x0010 in cycle N; c_rvalid=1 and rdata=0xBEEF in N+1; h_rvalid=0.
REQ-040 Host write: h_req=1, h_we=1, h_addr=0x0042, h_wdata=0x1234, c_req=0 -> h_gnt=1, mem_we=1, mem_addr=0x0042, mem_wdata=0x1234 for one cycle; no rvalid.
REQ-041 Starvation, STARVE_LIMIT=4: c_req and h_req held at 1 continuously -> c_gnt for 4 cycles, h_gnt on the 5th, then cpu wins again with wait_cnt=0; repeats with period 5.
REQ-042 Back-to-back cpu reads to 0x0001, 0x0002, 0x0003 on consecutive cycles -> three consecutive grants; c_rvalid high for three consecutive cycles with the matching data in order.
REQ-043 Reset mid-read: cpu read granted in cycle N, rst=0 asserted during N -> c_rvalid=0, rdata=0, wait_cnt=0 after release.
REQ-044 Random both-requester traffic checked against a reference memory model -> every read returns the last written value; no double grant; no host wait exceeding STARVE_LIMIT+1 cycles.
